// File: rtl/tank_pkg.sv
// Shared constants and types for the tank game projectile logic.
// Contents: grid geometry (GRID_W, COORD_W, POS_W), direction encoding,
// scheduler FSM state encoding and the {y,x} position struct.
// MAX_RANGE and RANGE_W are consumed only when PROJ_WRAP_EN is defined.
package tank_pkg;

  localparam int unsigned GRID_W    = 16;
  localparam int unsigned COORD_W   = 4;
  localparam int unsigned POS_W     = 2 * COORD_W;
  localparam int unsigned DIR_W     = 2;
  localparam int unsigned NUM_SLOTS = 2;
  localparam int unsigned RANGE_W   = 4;
  localparam int unsigned MAX_RANGE = 12;

  typedef enum logic [DIR_W-1:0] {
    DIR_UP    = 2'd0,  // y-1
    DIR_RIGHT = 2'd1,  // x+1
    DIR_DOWN  = 2'd2,  // y+1
    DIR_LEFT  = 2'd3   // x-1
  } dir_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STEP_1 = 2'd1,
    ST_STEP_2 = 2'd2
  } sched_state_e;

  typedef struct packed {
    logic [COORD_W-1:0] y;
    logic [COORD_W-1:0] x;
  } pos_t;

endpackage

// File: rtl/proj_step.sv
// Single-step projectile mover, time-shared between both projectile slots.
// Ports:
//   pos      in  POS_W  current position {y,x}
//   dir      in  dir_e  travel direction
//   nxt_pos  out POS_W  position after one step (coordinates wrap modulo 16)
//   off_grid out 1      the step would leave the 0..15 range on x or y
// Purely combinational; the caller decides whether to kill or wrap
// (PROJ_WRAP_EN selects wrapping in the scheduler).
module proj_step
  import tank_pkg::*;
(
  input  logic [POS_W-1:0] pos,
  input  dir_e             dir,
  output logic [POS_W-1:0] nxt_pos,
  output logic             off_grid
);

  pos_t cur;
  pos_t nxt;

  // 4-bit coordinate arithmetic wraps naturally; off_grid flags the edge cross
  always_comb begin
    cur      = pos_t'(pos);
    nxt      = cur;
    off_grid = 1'b0;
    unique case (dir)
      DIR_UP: begin
        nxt.y    = cur.y - COORD_W'(1);
        off_grid = (cur.y == '0);
      end
      DIR_RIGHT: begin
        nxt.x    = cur.x + COORD_W'(1);
        off_grid = (cur.x == '1);
      end
      DIR_DOWN: begin
        nxt.y    = cur.y + COORD_W'(1);
        off_grid = (cur.y == '1);
      end
      DIR_LEFT: begin
        nxt.x    = cur.x - COORD_W'(1);
        off_grid = (cur.x == '0);
      end
    endcase
    nxt_pos = POS_W'(nxt);
  end

endmodule

// File: rtl/projectile_scheduler.sv
// Projectile scheduler: owns both players' projectile slots, arbitrates fire
// requests and steps each slot once per game tick through one shared
// proj_step unit (slot 1 in STEP_1, slot 2 in STEP_2).
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   tick              one-cycle game-tick pulse (dropped while busy)
//   fire_req[1:0]     level requests, [0]=player 1, [1]=player 2
//   fire_dir_1/_2     direction latched at launch
//   player_1/2_pos    tank positions {y,x}
//   fire_ack[1:0]     one-cycle accept pulse per requester
//   proj_1/2_pos      slot positions
//   proj_active[1:0]  slot valid flags
//   hit[1:0]          [0]=player 1 hit by slot 2, [1]=player 2 hit by slot 1
//   busy              high in STEP_1 and STEP_2
// Build option: define PROJ_WRAP_EN to wrap at the grid edge and expire
// projectiles after MAX_RANGE steps instead of killing them at the edge.
module projectile_scheduler
  import tank_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tick,
  input  logic [NUM_SLOTS-1:0] fire_req,
  input  logic [DIR_W-1:0]     fire_dir_1,
  input  logic [DIR_W-1:0]     fire_dir_2,
  input  logic [POS_W-1:0]     player_1_pos,
  input  logic [POS_W-1:0]     player_2_pos,
  output logic [NUM_SLOTS-1:0] fire_ack,
  output logic [POS_W-1:0]     proj_1_pos,
  output logic [POS_W-1:0]     proj_2_pos,
  output logic [NUM_SLOTS-1:0] proj_active,
  output logic [NUM_SLOTS-1:0] hit,
  output logic                 busy
);

  sched_state_e state_q;
  logic         busy_q;
  logic         rr_q, rr_d;

  logic [NUM_SLOTS-1:0]            active_q, active_d;
  logic [NUM_SLOTS-1:0]            ack_q, ack_d;
  logic [NUM_SLOTS-1:0]            hit_q, hit_d;
  logic [NUM_SLOTS-1:0][POS_W-1:0] pos_q, pos_d;
  logic [NUM_SLOTS-1:0][DIR_W-1:0] dir_q, dir_d;

`ifdef PROJ_WRAP_EN
  logic [NUM_SLOTS-1:0][RANGE_W-1:0] range_q, range_d;
  logic [RANGE_W-1:0]                range_nxt;
`endif

  // Shared step datapath: slot index follows the FSM step cycle
  logic             sel;
  logic             stepping;
  logic [POS_W-1:0] step_pos;
  dir_e             step_dir;
  logic [POS_W-1:0] step_nxt;
  logic             step_off;
  logic [POS_W-1:0] target;

  logic [NUM_SLOTS-1:0] elig;
  logic                 win;

  assign sel      = (state_q == ST_STEP_2);
  assign stepping = (state_q != ST_IDLE) && active_q[sel];
  assign step_pos = pos_q[sel];
  assign step_dir = dir_e'(dir_q[sel]);
  // Each slot is checked against the opposing player, sampled this cycle
  assign target   = sel ? player_1_pos : player_2_pos;

  proj_step u_proj_step (
    .pos      (step_pos),
    .dir      (step_dir),
    .nxt_pos  (step_nxt),
    .off_grid (step_off)
  );

  // Next-state for slots, handshake pulses and round-robin pointer
  always_comb begin
    pos_d    = pos_q;
    dir_d    = dir_q;
    active_d = active_q;
    ack_d    = '0;
    hit_d    = '0;
    rr_d     = rr_q;
    elig     = '0;
    win      = 1'b0;
`ifdef PROJ_WRAP_EN
    range_d   = range_q;
    range_nxt = range_q[sel] + RANGE_W'(1);
`endif

    if (stepping) begin
`ifdef PROJ_WRAP_EN
      pos_d[sel]   = step_nxt;
      range_d[sel] = range_nxt;
      if (step_nxt == target) begin
        active_d[sel] = 1'b0;
        hit_d[~sel]   = 1'b1;
      end else if (range_nxt == RANGE_W'(MAX_RANGE)) begin
        active_d[sel] = 1'b0;
      end
`else
      if (step_off) begin
        // Leaving the grid: slot dies, position keeps its last value
        active_d[sel] = 1'b0;
      end else begin
        pos_d[sel] = step_nxt;
        if (step_nxt == target) begin
          active_d[sel] = 1'b0;
          hit_d[~sel]   = 1'b1;
        end
      end
`endif
    end

    // Fire arbitration only in an idle cycle without a tick (tick wins)
    if ((state_q == ST_IDLE) && !tick) begin
      elig = fire_req & ~active_q;
      if (&elig) begin
        win  = rr_q;
        rr_d = ~rr_q;
      end else begin
        win = ~elig[0];
      end
      if (|elig) begin
        ack_d[win]    = 1'b1;
        active_d[win] = 1'b1;
        pos_d[win]    = win ? player_2_pos : player_1_pos;
        dir_d[win]    = win ? fire_dir_2 : fire_dir_1;
`ifdef PROJ_WRAP_EN
        range_d[win]  = '0;
`endif
      end
    end
  end

  // FSM and all state registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      busy_q   <= 1'b0;
      rr_q     <= 1'b0;
      active_q <= '0;
      ack_q    <= '0;
      hit_q    <= '0;
      pos_q    <= '0;
      dir_q    <= '0;
`ifdef PROJ_WRAP_EN
      range_q  <= '0;
`endif
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (tick) begin
            state_q <= ST_STEP_1;
            busy_q  <= 1'b1;
          end
        end
        ST_STEP_1: state_q <= ST_STEP_2;
        ST_STEP_2: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
      rr_q     <= rr_d;
      active_q <= active_d;
      ack_q    <= ack_d;
      hit_q    <= hit_d;
      pos_q    <= pos_d;
      dir_q    <= dir_d;
`ifdef PROJ_WRAP_EN
      range_q  <= range_d;
`endif
    end
  end

  assign fire_ack    = ack_q;
  assign hit         = hit_q;
  assign proj_active = active_q;
  assign proj_1_pos  = pos_q[0];
  assign proj_2_pos  = pos_q[1];
  assign busy        = busy_q;

endmodule

// File: tb/tb_projectile_scheduler.sv
// Bench for projectile_scheduler: directed scenarios plus randomized
// fire/tick traffic; a tick-level reference model pushes expected events
// (ack, hit, tick-complete) into a queue that an independent monitor drains.
module tb_projectile_scheduler;

  logic       clk;
  logic       reset;
  logic       tick;
  logic [1:0] fire_req;
  logic [1:0] fire_dir_1, fire_dir_2;
  logic [7:0] player_1_pos, player_2_pos;
  logic [1:0] fire_ack;
  logic [7:0] proj_1_pos, proj_2_pos;
  logic [1:0] proj_active;
  logic [1:0] hit;
  logic       busy;

  projectile_scheduler dut (
    .clk          (clk),
    .reset        (reset),
    .tick         (tick),
    .fire_req     (fire_req),
    .fire_dir_1   (fire_dir_1),
    .fire_dir_2   (fire_dir_2),
    .player_1_pos (player_1_pos),
    .player_2_pos (player_2_pos),
    .fire_ack     (fire_ack),
    .proj_1_pos   (proj_1_pos),
    .proj_2_pos   (proj_2_pos),
    .proj_active  (proj_active),
    .hit          (hit),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef enum int {EV_ACK, EV_HIT, EV_DONE} ev_kind_e;
  typedef struct {
    ev_kind_e   kind;
    int         idx;
    logic [7:0] p1;
    logic [7:0] p2;
    logic [1:0] act;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // ---------------- reference model (per-slot x/y integers) ----------------
  int m_x[2], m_y[2], m_dir[2], m_rng[2];
  bit m_act[2];
  bit m_rr;

  function automatic logic [7:0] mpos(int s);
    return 8'((m_y[s] << 4) | m_x[s]);
  endfunction

  function automatic void push(ev_kind_e k, int idx);
    exp_t e;
    e.kind = k;
    e.idx  = idx;
    e.p1   = mpos(0);
    e.p2   = mpos(1);
    e.act  = {m_act[1], m_act[0]};
    exp_q.push_back(e);
  endfunction

  function automatic void model_reset();
    for (int s = 0; s < 2; s++) begin
      m_x[s] = 0; m_y[s] = 0; m_dir[s] = 0; m_rng[s] = 0; m_act[s] = 1'b0;
    end
    m_rr = 1'b0;
  endfunction

  function automatic void model_step(int s);
    int nx, ny;
    logic [7:0] tgt;
    if (!m_act[s]) return;
    nx = m_x[s] + ((m_dir[s] == 1) ? 1 : (m_dir[s] == 3) ? -1 : 0);
    ny = m_y[s] + ((m_dir[s] == 2) ? 1 : (m_dir[s] == 0) ? -1 : 0);
`ifdef PROJ_WRAP_EN
    nx = nx & 15;
    ny = ny & 15;
    m_rng[s] = m_rng[s] + 1;
`else
    if (nx < 0 || nx > 15 || ny < 0 || ny > 15) begin
      m_act[s] = 1'b0;
      return;
    end
`endif
    m_x[s] = nx;
    m_y[s] = ny;
    tgt = (s == 0) ? player_2_pos : player_1_pos;
    if (mpos(s) == tgt) begin
      m_act[s] = 1'b0;
      push(EV_HIT, 1 - s);
    end
`ifdef PROJ_WRAP_EN
    else if (m_rng[s] == 12) m_act[s] = 1'b0;
`endif
  endfunction

  function automatic void model_tick();
    model_step(0);
    model_step(1);
    push(EV_DONE, 0);
  endfunction

  function automatic void model_accept(int s);
    logic [7:0] p;
    p = (s == 0) ? player_1_pos : player_2_pos;
    m_act[s] = 1'b1;
    m_x[s]   = int'(p[3:0]);
    m_y[s]   = int'(p[7:4]);
    m_dir[s] = (s == 0) ? int'(fire_dir_1) : int'(fire_dir_2);
    m_rng[s] = 0;
    push(EV_ACK, s);
  endfunction

  function automatic void model_fire(logic [1:0] mask);
    int first;
    if (mask == 2'b11) begin
      first = m_rr ? 1 : 0;
      m_rr  = ~m_rr;
      model_accept(first);
      model_accept(1 - first);
    end else if (mask != 2'b00) begin
      model_accept(mask[1] ? 1 : 0);
    end
  endfunction

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  int busy_cnt  = 0;
  bit busy_prev = 1'b0;

  task automatic mon_evt(input ev_kind_e k, input int idx);
    exp_t e;
    bit   ok;
    n_checks++;
    if (exp_q.size() == 0) begin
      $display("FAIL unexpected_event: got kind=%s idx=%0d, expected no event", k.name(), idx);
      return;
    end
    e  = exp_q.pop_front();
    ok = (e.kind == k) && (e.idx == idx) && (proj_1_pos === e.p1) &&
         (proj_2_pos === e.p2) && (proj_active === e.act) &&
         ((k != EV_DONE) || (busy_cnt == 2));
    if (ok) n_pass++;
    else $display("FAIL event_%s: got idx=%0d p1=%h p2=%h act=%b busy_cycles=%0d, expected kind=%s idx=%0d p1=%h p2=%h act=%b busy_cycles=2",
                  k.name(), idx, proj_1_pos, proj_2_pos, proj_active, busy_cnt,
                  e.kind.name(), e.idx, e.p1, e.p2, e.act);
  endtask

  // Monitor: samples on the falling edge, pops one expectation per DUT event
  always @(negedge clk) begin
    if (reset) begin
      busy_cnt  = 0;
      busy_prev = 1'b0;
    end else begin
      if (hit[1]) mon_evt(EV_HIT, 1);
      if (hit[0]) mon_evt(EV_HIT, 0);
      if (busy) busy_cnt++;
      else if (busy_prev) begin
        mon_evt(EV_DONE, 0);
        busy_cnt = 0;
      end
      busy_prev = busy;
      if (fire_ack[0]) mon_evt(EV_ACK, 0);
      if (fire_ack[1]) mon_evt(EV_ACK, 1);
    end
  end

  // ---------------- driver ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_players(input logic [7:0] p1, input logic [7:0] p2);
    player_1_pos = p1;
    player_2_pos = p2;
  endtask

  task automatic wait_idle();
    for (int c = 0; c < 20; c++) begin
      if (!busy) break;
      @(negedge clk);
    end
    if (busy) begin
      n_checks++;
      $display("FAIL busy_timeout: got busy=1, expected 0");
    end
    cyc();
  endtask

  // mask must only name slots the model holds inactive
  task automatic do_fire(input logic [1:0] mask, input bit with_tick);
    logic [1:0] pending;
    fire_req = mask;
    tick     = with_tick;
    if (with_tick) model_tick();
    model_fire(mask);
    cyc();
    tick    = 1'b0;
    pending = mask;
    for (int c = 0; c < 20 && pending != 2'b00; c++) begin
      @(negedge clk);
      pending  = pending & ~fire_ack;
      fire_req = fire_req & ~fire_ack;
    end
    if (pending != 2'b00) begin
      n_checks++;
      $display("FAIL ack_timeout: got pending=%b, expected 00", pending);
      fire_req = 2'b00;
    end
    cyc();
  endtask

  task automatic do_tick(input bit extra);
    tick = 1'b1;
    model_tick();
    cyc();
    tick = extra;  // a second tick during STEP_1 must be dropped
    cyc();
    tick = 1'b0;
    wait_idle();
  endtask

  task automatic clear_slots();
    for (int i = 0; i < 40 && (m_act[0] || m_act[1]); i++) do_tick(1'b0);
  endtask

  function automatic logic [3:0] rcoord();
    if ($urandom_range(0, 1) == 1) return 4'($urandom_range(0, 3));
    return 4'($urandom_range(0, 15));
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1);
  end

  initial begin
    logic [1:0] inact, mask;
    int         op;

    reset = 1'b1; tick = 1'b0; fire_req = 2'b00;
    fire_dir_1 = 2'd0; fire_dir_2 = 2'd0;
    set_players(8'h00, 8'h00);
    model_reset();
    cyc(); cyc();
    chk("rst_active", 16'(proj_active), 16'h0);
    chk("rst_pos1",   16'(proj_1_pos),  16'h0);
    chk("rst_pos2",   16'(proj_2_pos),  16'h0);
    chk("rst_busy",   16'(busy),        16'h0);
    chk("rst_ack",    16'(fire_ack),    16'h0);
    chk("rst_hit",    16'(hit),         16'h0);
    reset = 1'b0;
    cyc();

    // Reset held two cycles in the middle of STEP_1 with both slots live
    set_players(8'h44, 8'hAA);
    fire_dir_1 = 2'd0; fire_dir_2 = 2'd3;
    do_fire(2'b11, 1'b0);
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    chk("t1_busy_step1", 16'(busy), 16'h1);
    reset = 1'b1;
    cyc(); cyc();
    reset = 1'b0;
    chk("t1_active", 16'(proj_active), 16'h0);
    chk("t1_pos1",   16'(proj_1_pos),  16'h0);
    chk("t1_pos2",   16'(proj_2_pos),  16'h0);
    chk("t1_busy",   16'(busy),        16'h0);
    exp_q.delete();
    model_reset();
    cyc();
    chk("t1_idle_next", 16'(busy), 16'h0);
    do_tick(1'b0);

    // P1 at 00 fires right, three ticks
    set_players(8'h00, 8'h80);
    fire_dir_1 = 2'd1;
    do_fire(2'b01, 1'b0);
    do_tick(1'b0); do_tick(1'b0); do_tick(1'b0);
    chk("t2_pos_after3", 16'(proj_1_pos), 16'h03);
    clear_slots();

    // Simultaneous requests twice: rr pointer alternates the winner
    set_players(8'h0F, 8'hF0);
    fire_dir_1 = 2'd1; fire_dir_2 = 2'd2;
    do_fire(2'b11, 1'b0);
    do_tick(1'b0);
    do_fire(2'b11, 1'b0);
    clear_slots();

    // Slot 1 steps onto player 2
    set_players(8'h3E, 8'h3F);
    fire_dir_1 = 2'd1;
    do_fire(2'b01, 1'b0);
    do_tick(1'b0);
    chk("t4_pos1",   16'(proj_1_pos),     16'h3F);
    chk("t4_active", 16'(proj_active[0]), 16'h0);

    // Slot 2 at bottom edge moving down
    set_players(8'h00, 8'hF5);
    fire_dir_2 = 2'd2;
    do_fire(2'b10, 1'b0);
    do_tick(1'b0);
`ifdef PROJ_WRAP_EN
    chk("t5_pos2_wrap",   16'(proj_2_pos),     16'h05);
    chk("t5_active_wrap", 16'(proj_active[1]), 16'h1);
    for (int i = 0; i < 10; i++) do_tick(1'b0);
    chk("t5_alive_11", 16'(proj_active[1]), 16'h1);
    do_tick(1'b0);
    chk("t5_dead_12",  16'(proj_active[1]), 16'h0);
`else
    chk("t5_pos2_held", 16'(proj_2_pos),     16'hF5);
    chk("t5_active",    16'(proj_active[1]), 16'h0);
`endif
    clear_slots();

    // Fire request in the same cycle as a tick
    set_players(8'h11, 8'h22);
    fire_dir_1 = 2'd2;
    do_fire(2'b01, 1'b1);
    clear_slots();

    // Randomized traffic
    for (int it = 0; it < 150; it++) begin
      set_players({rcoord(), rcoord()}, {rcoord(), rcoord()});
      fire_dir_1 = 2'($urandom_range(0, 3));
      fire_dir_2 = 2'($urandom_range(0, 3));
      inact = {~m_act[1], ~m_act[0]};
      op    = int'($urandom_range(0, 9));
      if (inact != 2'b00 && op < 6) begin
        mask = inact & 2'($urandom_range(1, 3));
        if (mask == 2'b00) mask = inact;
        do_fire(mask, op < 2);
      end else begin
        do_tick(op == 9);
      end
    end

    cyc(); cyc(); cyc();
    chk("queue_drained", 16'(exp_q.size()), 16'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
